square_root_cordic_cu: RTL and testbench

SQUARE_ROOT_CORDIC_CU -- requirements
Module: square_root_cordic_CU

---
 rtl/square_root_cordic_cu_if.sv | 19 +
 rtl/square_root_cordic_cu.sv | 81 ++++++++
 tb/tb_square_root_cordic_cu.sv | 138 +++++++++++++
 3 files changed

// File: rtl/square_root_cordic_cu_if.sv
// square_root_cordic_cu_if: handshake, status-flag and control bundle between CORDIC sqrt controller and datapath.
interface square_root_cordic_cu_if;
    logic       start;
    logic       co, repeat_iter, neg, zero_flag, one_flag;
    logic       loadS, loadE, loadM, loadE_out, loadX, loadY, init_cnt, en_cnt;
    logic [1:0] src_x;
    logic       src_y;
    logic       busy, done, invalid;
    modport slave (
        input  start, co, repeat_iter, neg, zero_flag, one_flag,
        output loadS, loadE, loadM, loadE_out, loadX, loadY, init_cnt, en_cnt,
        output src_x, src_y, busy, done, invalid
    );
    modport master (
        output start, co, repeat_iter, neg, zero_flag, one_flag,
        input  loadS, loadE, loadM, loadE_out, loadX, loadY, init_cnt, en_cnt,
        input  src_x, src_y, busy, done, invalid
    );
endinterface

// File: rtl/square_root_cordic_cu.sv
// square_root_cordic_cu: control FSM sequencing load, special-case check, hyperbolic CORDIC iterations and scaling.
module square_root_cordic_cu #(
    parameter int NUM_ITER = 16
) (
    input logic clk,
    input logic rst,
    square_root_cordic_cu_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, INIT, ITER, SCALE, DONE} state_t;
    localparam int W = $clog2(2 * NUM_ITER + 4);
    localparam logic [W-1:0] ITER_MAX = W'(2 * NUM_ITER);
    state_t state_q, state_d;
    logic rep_q, invalid_q, rep_pend;
    logic load_s_q, load_e_q, load_m_q, load_e_out_q, load_x_q, load_y_q, init_cnt_q;
    logic src_y_q, busy_q, done_q;
    logic [1:0] src_x_q;
    logic [W-1:0] itc_q;
    // a repeat index runs twice before the counter is allowed to advance
    assign rep_pend = bus.repeat_iter && !rep_q;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? LOAD : IDLE;
            LOAD:    state_d = CHECK;
            CHECK:   state_d = (bus.neg || bus.zero_flag || bus.one_flag) ? DONE : INIT;
            INIT:    state_d = ITER;
            ITER:    state_d = (bus.co && !rep_pend) ? SCALE : ITER;
            SCALE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rep_q        <= 1'b0;
            invalid_q    <= 1'b0;
            load_s_q     <= 1'b0;
            load_e_q     <= 1'b0;
            load_m_q     <= 1'b0;
            load_e_out_q <= 1'b0;
            load_x_q     <= 1'b0;
            load_y_q     <= 1'b0;
            init_cnt_q   <= 1'b0;
            src_x_q      <= 2'b00;
            src_y_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            itc_q        <= '0;
        end else begin
            state_q      <= state_d;
            rep_q        <= (state_q == ITER) && rep_pend;
            invalid_q    <= (state_q == CHECK) ? bus.neg : invalid_q;
            load_s_q     <= state_d == LOAD;
            load_e_q     <= state_d == LOAD;
            load_m_q     <= state_d == LOAD;
            load_e_out_q <= state_d == CHECK;
            load_x_q     <= state_d inside {INIT, ITER, SCALE};
            load_y_q     <= state_d inside {INIT, ITER};
            init_cnt_q   <= state_d == INIT;
            src_x_q      <= (state_d == ITER) ? 2'b01 : (state_d == SCALE) ? 2'b10 : 2'b00;
            src_y_q      <= state_d == ITER;
            busy_q       <= !(state_d inside {IDLE, DONE});
            done_q       <= state_d == DONE;
            itc_q        <= (state_q == ITER) ? itc_q + 1'b1 : '0;
            assert (itc_q <= ITER_MAX);
        end
    end
    assign bus.en_cnt    = (state_q == ITER) && !rep_pend;
    assign bus.loadS     = load_s_q;
    assign bus.loadE     = load_e_q;
    assign bus.loadM     = load_m_q;
    assign bus.loadE_out = load_e_out_q;
    assign bus.loadX     = load_x_q;
    assign bus.loadY     = load_y_q;
    assign bus.init_cnt  = init_cnt_q;
    assign bus.src_x     = src_x_q;
    assign bus.src_y     = src_y_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.invalid   = invalid_q;
endmodule

// File: tb/tb_square_root_cordic_cu.sv
// tb_square_root_cordic_cu: directed bench with a counter/flag datapath model and an expected-result scoreboard.
module tb_square_root_cordic_cu;
    localparam int NUM_ITER = 16;
    typedef struct {
        int lat;
        int inv;
        int iters;
        int zeros;
        int lx;
        int eo;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] u = 32'h0;
    logic [4:0] cnt = 5'd0;
    int total = 0;
    int bad = 0;
    exp_t sb[$];
    logic [12:0] ctl;
    always #5 clk = ~clk;
    square_root_cordic_cu_if bus();
    square_root_cordic_cu #(.NUM_ITER(NUM_ITER)) dut (.clk(clk), .rst(rst), .bus(bus));
    always_ff @(posedge clk) cnt <= bus.init_cnt ? 5'd1 : (bus.en_cnt ? cnt + 5'd1 : cnt);
    assign bus.co          = cnt == 5'(NUM_ITER);
    assign bus.repeat_iter = (cnt == 5'd4) || (cnt == 5'd13);
    assign bus.neg         = u[31];
    assign bus.zero_flag   = u[30:0] == 31'd0;
    assign bus.one_flag    = u == 32'h3F80_0000;
    assign ctl = {bus.loadS, bus.loadE, bus.loadM, bus.loadE_out, bus.loadX, bus.loadY,
                  bus.init_cnt, bus.en_cnt, bus.src_x, bus.src_y, bus.busy, bus.done};
    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic run_op(input string tag, input logic [31:0] val, input exp_t e);
        int n, iters, zeros, lx, eo;
        exp_t got;
        n = 1; iters = 0; zeros = 0; lx = 0; eo = 0;
        u = val;
        bus.start = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (n <= 60 && !bus.done) begin
            if (bus.loadY && bus.src_y) iters++;
            if (bus.loadY && bus.src_y && !bus.en_cnt) zeros++;
            if (bus.loadX) lx++;
            if (bus.loadE_out) eo = n;
            @(posedge clk); #1;
            n++;
        end
        got = sb.pop_front();
        check({tag, "_lat"}, n, got.lat);
        check({tag, "_inv"}, int'(bus.invalid), got.inv);
        check({tag, "_iters"}, iters, got.iters);
        check({tag, "_hold"}, zeros, got.zeros);
        check({tag, "_loadx"}, lx, got.lx);
        check({tag, "_eout"}, eo, got.eo);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_idle_ctl"}, int'(ctl), 0);
        check({tag, "_inv_held"}, int'(bus.invalid), got.inv);
    endtask
    initial begin
        int n, loads, last_load, dones, busy_done;
        exp_t norm, byp;
        norm = '{lat: 23, inv: 0, iters: 18, zeros: 2, lx: 20, eo: 2};
        byp  = '{lat: 3, inv: 0, iters: 0, zeros: 0, lx: 0, eo: 2};
        bus.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", int'(ctl), 0);
        check("reset_inv", int'(bus.invalid), 0);
        bus.start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("four", 32'h4080_0000, norm);
        run_op("zero", 32'h0000_0000, byp);
        run_op("neg4", 32'hC080_0000, '{lat: 3, inv: 1, iters: 0, zeros: 0, lx: 0, eo: 2});
        run_op("nine", 32'h4110_0000, norm);
        run_op("one", 32'h3F80_0000, byp);
        // abort mid-iteration with start also high: reset must win
        u = 32'h4080_0000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_busy_before", int'(bus.busy), 1);
        rst = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        check("abort_ctl", int'(ctl), 0);
        check("abort_inv", int'(bus.invalid), 0);
        rst = 1'b0;
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done || bus.busy) dones++;
            @(posedge clk); #1;
        end
        check("abort_no_done", dones, 0);
        run_op("after_abort", 32'h4080_0000, norm);
        // start held high: next LOAD only after DONE has returned to IDLE
        u = 32'h4080_0000;
        bus.start = 1'b1;
        loads = 0; last_load = 0; dones = 0; busy_done = 0;
        @(posedge clk); #1;
        for (n = 1; n <= 40; n++) begin
            if (bus.loadS) begin
                loads++;
                last_load = n;
            end
            if (bus.done) dones++;
            if (bus.done && bus.busy) busy_done++;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check("held_loads", loads, 2);
        check("held_second_load", last_load, 25);
        check("held_dones", dones, 1);
        check("held_busy_in_done", busy_done, 0);
        n = 0;
        while (n < 60 && !bus.done) begin
            @(posedge clk); #1;
            n++;
        end
        check("held_second_done", int'(bus.done), 1);
        repeat (2) @(posedge clk);
        #1;
        check("held_final_idle", int'(ctl), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
